// File: rtl/disp_req_arbiter.sv
// Round-robin owner arbiter for the shared two-digit display, with minimum grant hold time.
// Optional per-requester digit blinking when DISP_ARB_BLINK_EN is defined.
module disp_req_arbiter #(
  parameter int         N_REQ      = 4,
  parameter int         HOLD_CYC   = 1000,
  parameter logic [3:0] BLANK_CODE = 4'hF
`ifdef DISP_ARB_BLINK_EN
  ,
  parameter int         BLINK_HALF = 250
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [4*N_REQ-1:0] i_ones,
  input  logic [4*N_REQ-1:0] i_tens,
`ifdef DISP_ARB_BLINK_EN
  input  logic [N_REQ-1:0]   i_blink,
`endif
  output logic [N_REQ-1:0]   o_gnt,
  output logic [3:0]         o_ones,
  output logic [3:0]         o_tens,
  output logic               o_busy,
  output logic               o_done
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int HC_W  = $clog2(HOLD_CYC + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           state;
  logic [PTR_W-1:0] last_ptr;
  logic [HC_W-1:0]  hold_cnt;
  logic [3:0]       ones_q;
  logic [3:0]       tens_q;

  logic [N_REQ-1:0] cand;
  logic             win_vld;
  logic [PTR_W-1:0] win_idx;
  logic             take;
  logic             rel;
  int               j;

  // Downward scan so the last hit is the first requester after last_ptr.
  always_comb begin
    cand    = i_req & ~o_gnt;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      j = int'(last_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (cand[j]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(j);
      end
    end
  end

  always_comb begin
    rel  = 1'b0;
    take = 1'b0;
    if (state == S_GRANT)
      rel = !i_req[last_ptr] || (hold_cnt == '0 && win_vld);
    if (win_vld)
      take = (state == S_IDLE) || rel;
  end

`ifdef DISP_ARB_BLINK_EN
  localparam int BH_W = $clog2(BLINK_HALF + 1);
  logic [BH_W-1:0] phase_cnt;
  logic            phase_off;
  logic            blink_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      o_gnt    <= '0;
      o_done   <= 1'b0;
      ones_q   <= BLANK_CODE;
      tens_q   <= BLANK_CODE;
      hold_cnt <= '0;
      last_ptr <= PTR_W'(N_REQ - 1);
`ifdef DISP_ARB_BLINK_EN
      phase_cnt <= '0;
      phase_off <= 1'b0;
      blink_q   <= 1'b0;
`endif
    end else begin
      o_done <= rel;
      if (take) begin
        state    <= S_GRANT;
        o_gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        last_ptr <= win_idx;
        hold_cnt <= HC_W'(HOLD_CYC - 1);
        ones_q   <= i_ones[4*win_idx +: 4];
        tens_q   <= i_tens[4*win_idx +: 4];
`ifdef DISP_ARB_BLINK_EN
        phase_cnt <= '0;
        phase_off <= 1'b0;
        blink_q   <= i_blink[win_idx];
`endif
      end else if (rel || state == S_IDLE) begin
        state  <= S_IDLE;
        o_gnt  <= '0;
        ones_q <= BLANK_CODE;
        tens_q <= BLANK_CODE;
`ifdef DISP_ARB_BLINK_EN
        phase_cnt <= '0;
        phase_off <= 1'b0;
        blink_q   <= 1'b0;
`endif
      end else begin
        hold_cnt <= (hold_cnt == '0) ? '0 : hold_cnt - 1'b1;
        ones_q   <= i_ones[4*last_ptr +: 4];
        tens_q   <= i_tens[4*last_ptr +: 4];
`ifdef DISP_ARB_BLINK_EN
        blink_q <= i_blink[last_ptr];
        if (phase_cnt == BH_W'(BLINK_HALF - 1)) begin
          phase_cnt <= '0;
          phase_off <= ~phase_off;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end
`endif
      end
    end
  end

  assign o_busy = |o_gnt;

`ifdef DISP_ARB_BLINK_EN
  assign o_ones = (blink_q && phase_off) ? BLANK_CODE : ones_q;
  assign o_tens = (blink_q && phase_off) ? BLANK_CODE : tens_q;
`else
  assign o_ones = ones_q;
  assign o_tens = tens_q;
`endif

endmodule
